// File: rtl/nes_clk_pkg.sv
// Shared clocking definitions for the NES core.
// Contents:
//   seq_state_t      - clock/reset sequencer state (WAIT/STAB/HOLD/RUN)
//   PPU_DIV_DEFAULT  - master cycles per PPU clock enable (shared with PPU)
//   CPU_DIV_DEFAULT  - master cycles per CPU clock enable (shared with APU)
//   cnt_width()      - counter width helper, never returns 0
package nes_clk_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_STAB = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } seq_state_t;

    localparam int unsigned PPU_DIV_DEFAULT = 4;
    localparam int unsigned CPU_DIV_DEFAULT = 12;

    // Width needed to count 0..n-1, at least one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports:
//   clk    in  destination clock
//   rst_n  in  asynchronous active-low reset, clears both flops to 0
//   d_i    in  asynchronous input level
//   q_o    out synchronised level, two clk cycles of latency
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/nes_clk_rst_seq.sv
// NES clock/reset sequencer, clocked by the PLL divided output.
// Qualifies the PLL lock, releases a synchronous system reset after a
// stable-lock window plus a hold window, generates PPU/CPU clock enables
// and counts lock losses seen while running.
// Ports:
//   clk            in   master clock
//   rst_n          in   asynchronous active-low reset
//   pll_lock       in   raw PLL lock, asynchronous to clk
//   sys_rst_n      out  active-low reset to the NES core, 1 only in RUN
//   ce_ppu         out  one-cycle PPU clock enable
//   ce_cpu         out  one-cycle CPU clock enable
//   seq_state      out  sequencer state for debug (0 WAIT .. 3 RUN)
//   lost_lock_cnt  out  saturating count of lock losses while running
module nes_clk_rst_seq
    import nes_clk_pkg::*;
#(
    parameter int unsigned LOCK_STABLE = 4096,
    parameter int unsigned RST_HOLD    = 64,
    parameter int unsigned PPU_DIV     = PPU_DIV_DEFAULT,
    parameter int unsigned CPU_DIV     = CPU_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       sys_rst_n,
    output logic       ce_ppu,
    output logic       ce_cpu,
    output logic [1:0] seq_state,
    output logic [7:0] lost_lock_cnt
);

    localparam int unsigned CNT_MAX = (LOCK_STABLE > RST_HOLD) ? LOCK_STABLE : RST_HOLD;
    localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
    localparam int unsigned PH_W    = cnt_width(CPU_DIV);

    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CPU_DIV - 1);

    generate
        if (PPU_DIV == 0 || (CPU_DIV % PPU_DIV) != 0) begin : g_div_check
            $error("CPU_DIV must be an integer multiple of PPU_DIV");
        end
    endgenerate

    logic lock_s;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [7:0]       lost_q, lost_d;
    logic             run_q, run_d;
    logic             ce_ppu_q, ce_ppu_d;
    logic             ce_cpu_q, ce_cpu_d;
    seq_state_t       seq_q, seq_d;

    // Sequencing FSM with the shared qualification/hold counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_WAIT: begin
                if (lock_s) begin
                    state_d = ST_STAB;
                    cnt_d   = '0;
                end
            end
            ST_STAB: begin
                if (!lock_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == STAB_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs. The output view of RUN starts one edge after the
    // FSM enters RUN and ends on the same edge the FSM leaves it, so a lock
    // loss clears reset and strobes without extra latency. The debug state
    // keeps showing HOLD during that first internal RUN cycle so that
    // seq_state==RUN always coincides with sys_rst_n==1.
    always_comb begin
        run_d    = (state_q == ST_RUN) && lock_s;
        seq_d    = (state_d == ST_RUN && !run_d) ? ST_HOLD : state_d;
        ce_ppu_d = run_d && ((32'(phase_q) % PPU_DIV) == 32'd0);
        ce_cpu_d = run_d && (phase_q == '0);
        phase_d  = '0;
        if (run_d) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        end
        lost_d = lost_q;
        if (state_q == ST_RUN && !lock_s && lost_q != 8'hFF) begin
            lost_d = lost_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_WAIT;
            cnt_q    <= '0;
            phase_q  <= '0;
            lost_q   <= '0;
            run_q    <= 1'b0;
            ce_ppu_q <= 1'b0;
            ce_cpu_q <= 1'b0;
            seq_q    <= ST_WAIT;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            lost_q   <= lost_d;
            run_q    <= run_d;
            ce_ppu_q <= ce_ppu_d;
            ce_cpu_q <= ce_cpu_d;
            seq_q    <= seq_d;
        end
    end

    assign sys_rst_n     = run_q;
    assign ce_ppu        = ce_ppu_q;
    assign ce_cpu        = ce_cpu_q;
    assign seq_state     = seq_q;
    assign lost_lock_cnt = lost_q;

endmodule

// File: tb/tb_nes_clk_rst_seq.sv
module tb_nes_clk_rst_seq;

    localparam int LS  = 16;
    localparam int RH  = 4;
    localparam int PPU = 4;
    localparam int CPU = 12;
    localparam int RUN_AT = LS + RH + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       sys_rst_n;
    logic       ce_ppu;
    logic       ce_cpu;
    logic [1:0] seq_state;
    logic [7:0] lost_lock_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: lock seen through a 2-cycle delay line, and a count
    // of consecutive cycles the delayed lock has been high.
    int m1 = 0, m2 = 0;
    int run_len = 0;
    int lost = 0;

    nes_clk_rst_seq #(
        .LOCK_STABLE (LS),
        .RST_HOLD    (RH),
        .PPU_DIV     (PPU),
        .CPU_DIV     (CPU)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_lock      (pll_lock),
        .sys_rst_n     (sys_rst_n),
        .ce_ppu        (ce_ppu),
        .ce_cpu        (ce_cpu),
        .seq_state     (seq_state),
        .lost_lock_cnt (lost_lock_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m1 = 0; m2 = 0; run_len = 0; lost = 0;
    endtask

    task automatic model_edge();
        int s;
        int prev;
        s = m2; m2 = m1; m1 = int'(pll_lock);
        prev = run_len;
        run_len = (s != 0) ? run_len + 1 : 0;
        // Lock lost while the sequencer itself was already in RUN.
        if (s == 0 && prev >= LS + RH + 1 && lost < 255) lost++;
    endtask

    task automatic check_all();
        int exp_run, exp_st, p;
        exp_run = (run_len >= RUN_AT) ? 1 : 0;
        p = run_len - RUN_AT;
        if (run_len == 0)            exp_st = 0;
        else if (run_len <= LS)      exp_st = 1;
        else if (run_len < RUN_AT)   exp_st = 2;
        else                         exp_st = 3;
        check("sys_rst_n", int'(sys_rst_n), exp_run);
        check("ce_ppu", int'(ce_ppu), (exp_run == 1 && (p % PPU) == 0) ? 1 : 0);
        check("ce_cpu", int'(ce_cpu), (exp_run == 1 && (p % CPU) == 0) ? 1 : 0);
        check("seq_state", int'(seq_state), exp_st);
        check("lost_lock_cnt", int'(lost_lock_cnt), lost);
    endtask

    // Drive pll_lock for n cycles, checking after every edge.
    task automatic cycles(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            pll_lock = v;
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic async_reset_pulse();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        bit seen;

        // Reset state.
        #2;
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: no lock for 100 cycles.
        cycles(1'b0, 100);

        // 2: lock rises, measure edges until sys_rst_n goes high.
        seen = 1'b0;
        n = 0;
        while (!seen && n < 60) begin
            cycles(1'b1, 1);
            n++;
            if (sys_rst_n === 1'b1) seen = 1'b1;
        end
        check("rise_latency", n, 24);
        check("first_run_ce_cpu", int'(ce_cpu), 1);
        cycles(1'b1, 30);

        // 4: lock drop in RUN, then re-lock.
        cycles(1'b0, 5);
        check("lost_after_drop", int'(lost_lock_cnt), 1);
        cycles(1'b1, 40);

        // 3: drop during STAB (cnt 10) for 3 cycles, requalify.
        cycles(1'b0, 6);
        cycles(1'b1, 13);
        check("mid_stab_state", int'(seq_state), 1);
        cycles(1'b0, 3);
        cycles(1'b1, 40);
        check("lost_no_stab_inc", int'(lost_lock_cnt), 2);

        // Randomised lock patterns.
        for (int k = 0; k < 40; k++) begin
            cycles(1'b0, int'($urandom_range(1, 6)));
            cycles(1'b1, int'($urandom_range(1, 45)));
        end

        // 5: saturate the lost-lock counter.
        for (int k = 0; k < 260; k++) begin
            cycles(1'b1, 26);
            cycles(1'b0, 3);
        end
        check("lost_saturated", int'(lost_lock_cnt), 255);
        cycles(1'b1, 30);
        async_reset_pulse();
        check("lost_after_rst", int'(lost_lock_cnt), 0);
        cycles(1'b0, 5);

        // 6: reset during HOLD clears outputs without a clock edge.
        cycles(1'b1, 21);
        check("in_hold", int'(seq_state), 2);
        async_reset_pulse();
        check("state_after_rst", int'(seq_state), 0);
        cycles(1'b1, 40);
        check("rerun_after_rst", int'(sys_rst_n), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
